timer_sched: RTL and testbench
==============================

Name: timer_sched

Overview:
- Scheduler that shares one timer_scaled instance between N_REQ requesters.
- Each requester asks for a delay: a prescaler setting, a reload value and a tick-repeat count.
- Grants the timer round-robin and loads the granted configuration into it.
- Counts timer ticks and pulses a per-requester done when the delay expires.
- Sits between software-visible delay clients and the single hardware timer.

Parameters:
N_REQ, 4, number of requesters (2..8)
SCALER_BITS, 3, width of the prescaler select passed to the timer
DATA_BITS, 8, width of the timer reload value
REP_BITS, 4, width of the tick-repeat count

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
req  in  N_REQ  level request per requester; held high until done, dropping it aborts
req_ps  in  N_REQ*SCALER_BITS  packed prescaler select per requester (slot i at [i*SCALER_BITS +: SCALER_BITS])
req_period  in  N_REQ*DATA_BITS  packed reload value per requester
req_reps  in  N_REQ*REP_BITS  packed tick count per requester; 0 is treated as 1
ack  out  N_REQ  one-cycle pulse: request accepted, config latched
done  out  N_REQ  one-cycle pulse: delay expired
busy  out  1  high while not IDLE
grant_id  out  $clog2(N_REQ)  index of the current owner (valid while busy)
t_clr  out  1  one-cycle synchronous clear to the timer (drives its reset)
t_en  out  1  timer enable
t_ps  out  SCALER_BITS  timer prescaler select
t_d_in  out  DATA_BITS  timer reload value
t_tick  in  1  timer tick pulse, one cycle per timer period

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - ack, done, busy, t_clr, t_en = 0; grant_id, t_ps, t_d_in = 0.
  - RR pointer=0, tick counter=0.
  - Reset mid-operation abandons the owner silently; no done is pulsed.
- States: IDLE, LOAD, RUN, DONE. All outputs registered.
- IDLE:
  - If any req bit is set, select a winner round-robin, starting search at pointer.
  - Latch the winner's ps/period/reps (reps 0 -> 1) and go to LOAD.
  - Pointer <= winner+1 mod N_REQ.
- LOAD, 1 cycle:
  - ack[g]=1, t_clr=1, t_en=0, busy=1.
  - t_ps/t_d_in hold latched values from here until IDLE.
- RUN:
  - t_en=1.
  - Each t_tick increments the tick counter.
  - On the tick that makes count == reps, go to DONE.
- DONE, 1 cycle:
  - done[g]=1, t_en=0, then IDLE.
  - Counter cleared. busy stays high through DONE.
- Latency: req seen in IDLE at cycle 0 -> ack at cycle 1 -> t_en from cycle 2 -> done one cycle after the final tick.
- Abort: req[g] low while in LOAD or RUN -> IDLE next cycle.
  - t_en=0, no done, counter cleared.
  - Abort takes precedence over a same-cycle final t_tick.
- t_tick ignored outside RUN.
- Requests arriving while busy wait; no queueing beyond the level req.
- IDLE always lasts at least 1 cycle between grants.
- Only one ack and one done bit can be high at a time; ack and done are never high in the same cycle.
- Per-requester ps/period/reps inputs are sampled only in IDLE on the grant; later changes have no effect on the running delay.

Optional Feature:
- TIMER_SCHED_FIXED_PRIO_EN defined:
  - Arbitration is fixed priority, lowest index wins.
  - Pointer register is removed.
- Undefined (default): round-robin as above.

Decomposition:
- Package timer_sched_pkg holds:
  - state enum (IDLE, LOAD, RUN, DONE);
  - default widths;
  - an ID_BITS constant function ($clog2).
- One sub-module, timer_sched_arb: combinational round-robin/fixed-priority picker.
  - Inputs: req vector, pointer.
  - Outputs: found, index.

Test Plan:
1. Single request: req[1]=1, ps=2, period=5, reps=3; bench model ticks every 4 cycles -> ack[1] at cycle 1, t_clr at cycle 1, done[1] exactly once, one cycle after the 3rd t_tick; t_ps=2, t_d_in=5 held throughout.
2. All four req high continuously -> grants in order 0,1,2,3,0; busy low exactly 1 cycle between grants. With TIMER_SCHED_FIXED_PRIO_EN the order is 0,0,0.
3. reps=0 -> treated as 1: done after the first t_tick.
4. Drop req[2] during RUN after 1 of 4 ticks -> IDLE next cycle, no done[2], t_en=0, next pending requester granted.
5. req drop coincident with the final t_tick -> abort wins, done stays 0.
6. Assert rst low mid-RUN -> all outputs 0 immediately (async); after release, first grant goes to requester 0.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// ============================================================================
//  Module      : timer_sched_pkg
//  Description : Shared types and constants for the timer scheduler: FSM
//                state encoding, default widths and the index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_sched_pkg;

    // Default build-time dimensions of the scheduler
    localparam int DEF_N_REQ       = 4;
    localparam int DEF_SCALER_BITS = 3;
    localparam int DEF_DATA_BITS   = 8;
    localparam int DEF_REP_BITS    = 4;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Width of a requester index; never narrower than one bit
    function automatic int ID_BITS(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : timer_sched_pkg

`default_nettype wire

// File: rtl/timer_sched_arb.sv
// ============================================================================
//  Module      : timer_sched_arb
//  Description : Combinational requester picker. Default build searches
//                round-robin starting at ptr. With TIMER_SCHED_FIXED_PRIO_EN
//                defined the lowest set index wins and there is no ptr input.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_sched_arb
    import timer_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = ID_BITS(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
`ifndef TIMER_SCHED_FIXED_PRIO_EN
    input  logic [ID_W-1:0]  ptr,
`endif
    output logic             found,
    output logic [ID_W-1:0]  idx
);

`ifdef TIMER_SCHED_FIXED_PRIO_EN

    // Scan from the highest index down so the lowest set index is kept last
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                found = 1'b1;
                idx   = ID_W'(k);
            end
        end
    end

`else

    // Scan offsets from the pointer downwards so the smallest offset wins;
    // the pointer is always < N_REQ so one wrap subtraction suffices
    always_comb begin
        logic [ID_W:0] slot;
        found = 1'b0;
        idx   = '0;
        slot  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            slot = {1'b0, ptr} + (ID_W + 1)'(k);
            if (slot >= (ID_W + 1)'(N_REQ)) begin
                slot = slot - (ID_W + 1)'(N_REQ);
            end
            if (req[slot[ID_W-1:0]]) begin
                found = 1'b1;
                idx   = slot[ID_W-1:0];
            end
        end
    end

`endif

endmodule : timer_sched_arb

`default_nettype wire

// File: rtl/timer_sched.sv
// ============================================================================
//  Module      : timer_sched
//  Description : Shares one scaled timer between N_REQ delay requesters.
//                A winner is picked in IDLE, its prescaler/reload/repeat
//                config is latched, the timer is cleared (LOAD), enabled
//                (RUN) and done is pulsed after the requested number of
//                ticks. Dropping the owner's req aborts without a done.
//                Build option: TIMER_SCHED_FIXED_PRIO_EN selects fixed
//                lowest-index priority instead of round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int SCALER_BITS = DEF_SCALER_BITS,
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int REP_BITS    = DEF_REP_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*SCALER_BITS-1:0] req_ps,
    input  logic [N_REQ*DATA_BITS-1:0]   req_period,
    input  logic [N_REQ*REP_BITS-1:0]    req_reps,
    output logic [N_REQ-1:0]             ack,
    output logic [N_REQ-1:0]             done,
    output logic                         busy,
    output logic [ID_BITS(N_REQ)-1:0]    grant_id,
    output logic                         t_clr,
    output logic                         t_en,
    output logic [SCALER_BITS-1:0]       t_ps,
    output logic [DATA_BITS-1:0]         t_d_in,
    input  logic                         t_tick
);

    localparam int ID_W = ID_BITS(N_REQ);

    state_t                state;
    logic [REP_BITS-1:0]   reps_q;
    logic [REP_BITS-1:0]   tick_cnt;

    logic                  win_found;
    logic [ID_W-1:0]       win_idx;
    logic [SCALER_BITS-1:0] sel_ps;
    logic [DATA_BITS-1:0]  sel_period;
    logic [REP_BITS-1:0]   sel_reps;
    logic [REP_BITS-1:0]   sel_reps_eff;
    logic                  owner_req;
    logic                  last_tick;

`ifndef TIMER_SCHED_FIXED_PRIO_EN
    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       ptr_next;
`endif

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    timer_sched_arb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req   (req),
`ifndef TIMER_SCHED_FIXED_PRIO_EN
        .ptr   (ptr),
`endif
        .found (win_found),
        .idx   (win_idx)
    );

    // Configuration slot of the candidate winner
    assign sel_ps       = req_ps[win_idx*SCALER_BITS +: SCALER_BITS];
    assign sel_period   = req_period[win_idx*DATA_BITS +: DATA_BITS];
    assign sel_reps     = req_reps[win_idx*REP_BITS +: REP_BITS];
    // A repeat count of zero still waits for one tick
    assign sel_reps_eff = (sel_reps == '0) ? REP_BITS'(1) : sel_reps;

    // Owner still asking, and whether this tick completes the delay
    assign owner_req = req[grant_id];
    assign last_tick = t_tick && ((tick_cnt + REP_BITS'(1)) == reps_q);

`ifndef TIMER_SCHED_FIXED_PRIO_EN
    // Next search starts just after the winner, wrapping at N_REQ
    assign ptr_next = (win_idx == ID_W'(N_REQ - 1)) ? '0 : (win_idx + ID_W'(1));

    // Round-robin pointer advances on every grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if ((state == IDLE) && win_found) begin
            ptr <= ptr_next;
        end
    end
`endif

    // Scheduler FSM with registered outputs; ack/done/t_clr are pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ack      <= '0;
            done     <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
            t_clr    <= 1'b0;
            t_en     <= 1'b0;
            t_ps     <= '0;
            t_d_in   <= '0;
            reps_q   <= '0;
            tick_cnt <= '0;
        end else begin
            ack   <= '0;
            done  <= '0;
            t_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state        <= LOAD;
                        grant_id     <= win_idx;
                        ack[win_idx] <= 1'b1;
                        t_clr        <= 1'b1;
                        t_en         <= 1'b0;
                        busy         <= 1'b1;
                        t_ps         <= sel_ps;
                        t_d_in       <= sel_period;
                        reps_q       <= sel_reps_eff;
                        tick_cnt     <= '0;
                    end
                end
                LOAD: begin
                    if (!owner_req) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        t_en     <= 1'b0;
                        t_ps     <= '0;
                        t_d_in   <= '0;
                        tick_cnt <= '0;
                    end else begin
                        state <= RUN;
                        t_en  <= 1'b1;
                    end
                end
                RUN: begin
                    // Abort outranks a final tick arriving in the same cycle
                    if (!owner_req) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        t_en     <= 1'b0;
                        t_ps     <= '0;
                        t_d_in   <= '0;
                        tick_cnt <= '0;
                    end else if (last_tick) begin
                        state          <= DONE;
                        done[grant_id] <= 1'b1;
                        t_en           <= 1'b0;
                        tick_cnt       <= '0;
                    end else if (t_tick) begin
                        tick_cnt <= tick_cnt + REP_BITS'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    t_en     <= 1'b0;
                    t_ps     <= '0;
                    t_d_in   <= '0;
                    tick_cnt <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    t_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule : timer_sched

`default_nettype wire

// File: tb/tb_timer_sched.sv
// ============================================================================
//  Module      : tb_timer_sched
//  Description : Self-checking bench for timer_sched. Directed scenarios plus
//                a randomized run checked against a transaction-level model
//                of arbitration, config capture and tick counting.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_timer_sched;

    localparam int N  = 4;
    localparam int SB = 3;
    localparam int DB = 8;
    localparam int RB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*SB-1:0] req_ps;
    logic [N*DB-1:0] req_period;
    logic [N*RB-1:0] req_reps;
    logic [N-1:0]    ack;
    logic [N-1:0]    done;
    logic            busy;
    logic [1:0]      grant_id;
    logic            t_clr;
    logic            t_en;
    logic [SB-1:0]   t_ps;
    logic [DB-1:0]   t_d_in;
    logic            t_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_sched #(
        .N_REQ(N), .SCALER_BITS(SB), .DATA_BITS(DB), .REP_BITS(RB)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_ps(req_ps),
        .req_period(req_period), .req_reps(req_reps), .ack(ack),
        .done(done), .busy(busy), .grant_id(grant_id), .t_clr(t_clr),
        .t_en(t_en), .t_ps(t_ps), .t_d_in(t_d_in), .t_tick(t_tick)
    );

    // One clock: inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int i, input int ps, input int per, input int reps);
        req_ps[i*SB +: SB]     = SB'(ps);
        req_period[i*DB +: DB] = DB'(per);
        req_reps[i*RB +: RB]   = RB'(reps);
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; t_tick = 1'b0;
        req_ps = '0; req_period = '0; req_reps = '0;
        step(); step();
        rst = 1'b1;
        step();
    endtask

    // Reference arbitration: first requester at or after p (or lowest index)
    function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef TIMER_SCHED_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (r[k]) return k;
`else
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
`endif
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b0; req = '1; t_tick = 1'b1;
        req_ps = '1; req_period = '1; req_reps = '1;
        step(); step();
        checks++; if ({ack, done, busy, t_clr, t_en} !== '0) begin errors++;
            $display("FAIL reset_ctrl got ack=%b done=%b busy=%b clr=%b en=%b exp all 0", ack, done, busy, t_clr, t_en); end
        checks++; if ({grant_id, t_ps, t_d_in} !== '0) begin errors++;
            $display("FAIL reset_data got gid=%0d ps=%0d d=%0d exp 0", grant_id, t_ps, t_d_in); end
        req = '0; t_tick = 1'b0; rst = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_idle busy got %b exp 0", busy); end
    endtask

    task automatic test_single();
        int ndone = 0;
        do_reset();
        set_cfg(1, 2, 5, 3);
        req = 4'b0010;
        step();
        checks++; if (ack !== 4'b0010 || t_clr !== 1'b1 || t_en !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL single_load got ack=%b clr=%b en=%b busy=%b exp 0010 1 0 1", ack, t_clr, t_en, busy); end
        step();
        checks++; if (ack !== 4'b0000 || t_clr !== 1'b0 || t_en !== 1'b1) begin errors++;
            $display("FAIL single_run got ack=%b clr=%b en=%b exp 0000 0 1", ack, t_clr, t_en); end
        for (int tk = 1; tk <= 3; tk++) begin
            for (int c = 0; c < 3; c++) begin
                t_tick = 1'b0;
                step();
                if (done != 0) ndone++;
                checks++; if (done !== 4'b0000 || t_ps !== 3'd2 || t_d_in !== 8'd5) begin errors++;
                    $display("FAIL single_wait got done=%b ps=%0d d=%0d exp 0000 2 5", done, t_ps, t_d_in); end
            end
            t_tick = 1'b1;
            step();
            if (done != 0) ndone++;
            if (tk < 3) begin
                checks++; if (done !== 4'b0000 || t_en !== 1'b1) begin errors++;
                    $display("FAIL single_tick%0d got done=%b en=%b exp 0000 1", tk, done, t_en); end
            end else begin
                checks++; if (done !== 4'b0010 || t_en !== 1'b0 || busy !== 1'b1) begin errors++;
                    $display("FAIL single_done got done=%b en=%b busy=%b exp 0010 0 1", done, t_en, busy); end
            end
        end
        t_tick = 1'b0; req = '0;
        step();
        if (done != 0) ndone++;
        checks++; if (busy !== 1'b0 || ndone != 1) begin errors++;
            $display("FAIL single_end got busy=%b dones=%0d exp 0 1", busy, ndone); end
    endtask

    task automatic test_round_robin();
`ifdef TIMER_SCHED_FIXED_PRIO_EN
        int exp_ord[3] = '{0, 0, 0};
`else
        int exp_ord[5] = '{0, 1, 2, 3, 0};
`endif
        bit found;
        int waited;
        do_reset();
        for (int i = 0; i < N; i++) set_cfg(i, i, 10 + i, 1);
        req = '1;
        foreach (exp_ord[g]) begin
            found = 0; waited = 0;
            for (int c = 0; c < 8 && !found; c++) begin
                step();
                if (ack != 0) found = 1; else waited++;
            end
            checks++; if (!found) begin errors++;
                $display("FAIL rr_timeout grant %0d got no ack exp ack within 8 cycles", g); end
            else begin
                checks++; if (onehot_idx(ack) != exp_ord[g] || grant_id !== 2'(exp_ord[g])) begin errors++;
                    $display("FAIL rr_order grant %0d got %0d exp %0d", g, onehot_idx(ack), exp_ord[g]); end
                if (g > 0) begin
                    checks++; if (waited != 0) begin errors++;
                        $display("FAIL rr_gap got %0d extra idle cycles exp 0", waited); end
                end
            end
            step();
            t_tick = 1'b1;
            step();
            t_tick = 1'b0;
            step();
            checks++; if (busy !== 1'b0) begin errors++;
                $display("FAIL rr_idle busy got %b exp 0", busy); end
        end
    endtask

    task automatic test_reps_zero();
        do_reset();
        set_cfg(0, 1, 9, 0);
        req = 4'b0001;
        step(); step();
        checks++; if (t_en !== 1'b1) begin errors++;
            $display("FAIL reps0_en got %b exp 1", t_en); end
        t_tick = 1'b1;
        step();
        checks++; if (done !== 4'b0001) begin errors++;
            $display("FAIL reps0_done got %b exp 0001", done); end
        t_tick = 1'b0; req = '0;
        step();
    endtask

    task automatic test_abort();
        do_reset();
        set_cfg(2, 3, 7, 4);
        set_cfg(3, 1, 2, 1);
        req = 4'b1100;
        step();
        checks++; if (ack !== 4'b0100) begin errors++;
            $display("FAIL abort_grant got %b exp 0100", ack); end
        step();
        t_tick = 1'b1; step();
        t_tick = 1'b0; step(); step();
        checks++; if (t_en !== 1'b1 || done !== 4'b0000) begin errors++;
            $display("FAIL abort_pre got en=%b done=%b exp 1 0000", t_en, done); end
        req = 4'b1000;
        step();
        checks++; if (busy !== 1'b0 || t_en !== 1'b0 || done !== 4'b0000) begin errors++;
            $display("FAIL abort_idle got busy=%b en=%b done=%b exp 0 0 0000", busy, t_en, done); end
        step();
        checks++; if (ack !== 4'b1000 || t_ps !== 3'd1 || t_d_in !== 8'd2) begin errors++;
            $display("FAIL abort_next got ack=%b ps=%0d d=%0d exp 1000 1 2", ack, t_ps, t_d_in); end
    endtask

    task automatic test_abort_final_tick();
        do_reset();
        set_cfg(0, 0, 3, 2);
        req = 4'b0001;
        step(); step();
        t_tick = 1'b1; step();
        checks++; if (done !== 4'b0000) begin errors++;
            $display("FAIL aft_first got done=%b exp 0000", done); end
        req = 4'b0000;
        step();
        checks++; if (done !== 4'b0000 || busy !== 1'b0 || t_en !== 1'b0) begin errors++;
            $display("FAIL aft_abort got done=%b busy=%b en=%b exp 0000 0 0", done, busy, t_en); end
        t_tick = 1'b0;
        step();
        checks++; if (done !== 4'b0000 || ack !== 4'b0000) begin errors++;
            $display("FAIL aft_after got done=%b ack=%b exp 0000 0000", done, ack); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_cfg(1, 4, 6, 5);
        req = 4'b0010;
        step(); step();
        t_tick = 1'b1; step();
        t_tick = 1'b0;
        checks++; if (t_en !== 1'b1 || busy !== 1'b1) begin errors++;
            $display("FAIL ares_pre got en=%b busy=%b exp 1 1", t_en, busy); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({ack, done, busy, t_clr, t_en, grant_id, t_ps, t_d_in} !== '0) begin errors++;
            $display("FAIL ares_async got busy=%b en=%b gid=%0d ps=%0d d=%0d exp all 0", busy, t_en, grant_id, t_ps, t_d_in); end
        step();
        rst = 1'b1; req = 4'b1011;
        step();
        checks++; if (ack !== 4'b0001 || grant_id !== 2'd0) begin errors++;
            $display("FAIL ares_first got ack=%b gid=%0d exp 0001 0", ack, grant_id); end
    endtask

    task automatic test_random();
        int ps_a[N], per_a[N], rep_a[N];
        int ptr_m, w, need, cnt, mode, abort_at;
        bit fin;
        logic [N-1:0] rv;
        do_reset();
        ptr_m = 0;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                ps_a[i] = $urandom_range(0, 7); per_a[i] = $urandom_range(0, 255); rep_a[i] = $urandom_range(0, 5);
                set_cfg(i, ps_a[i], per_a[i], rep_a[i]);
            end
            rv  = req | N'($urandom_range(1, (1 << N) - 1));
            req = rv;
            w   = pick(rv, ptr_m);
            ptr_m = (w + 1) % N;
            need  = (rep_a[w] == 0) ? 1 : rep_a[w];
            mode  = $urandom_range(0, 5);
            abort_at = (mode == 1) ? $urandom_range(0, need - 1) : -1;
            t_tick = 1'($urandom);
            step();
            checks++; if (ack !== N'(1 << w) || grant_id !== 2'(w) || t_clr !== 1'b1 || t_ps !== SB'(ps_a[w]) || t_d_in !== DB'(per_a[w])) begin errors++;
                $display("FAIL rnd_grant it%0d got ack=%b gid=%0d ps=%0d d=%0d exp winner %0d ps=%0d d=%0d", it, ack, grant_id, t_ps, t_d_in, w, ps_a[w], per_a[w]); end
            for (int i = 0; i < N; i++) set_cfg(i, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 15));
            if (mode == 2) begin
                req[w] = 1'b0;
                step();
                checks++; if (busy !== 1'b0 || t_en !== 1'b0 || done !== '0) begin errors++;
                    $display("FAIL rnd_load_abort got busy=%b en=%b done=%b exp 0 0 0", busy, t_en, done); end
                continue;
            end
            t_tick = 1'($urandom);
            step();
            cnt = 0; fin = 0;
            for (int c = 0; c < 200 && !fin; c++) begin
                checks++; if (t_en !== 1'b1 || done !== '0 || t_ps !== SB'(ps_a[w]) || t_d_in !== DB'(per_a[w])) begin errors++;
                    $display("FAIL rnd_run it%0d got en=%b done=%b ps=%0d d=%0d exp 1 0 %0d %0d", it, t_en, done, t_ps, t_d_in, ps_a[w], per_a[w]); end
                t_tick = 1'($urandom);
                if (cnt == abort_at) begin
                    req[w] = 1'b0;
                    step();
                    checks++; if (busy !== 1'b0 || t_en !== 1'b0 || done !== '0) begin errors++;
                        $display("FAIL rnd_abort it%0d got busy=%b en=%b done=%b exp 0 0 0", it, busy, t_en, done); end
                    fin = 1;
                end else begin
                    step();
                    if (t_tick) cnt++;
                    if (cnt == need) begin
                        checks++; if (done !== N'(1 << w) || t_en !== 1'b0 || busy !== 1'b1) begin errors++;
                            $display("FAIL rnd_done it%0d got done=%b en=%b busy=%b exp %b 0 1", it, done, t_en, busy, N'(1 << w)); end
                        req[w] = 1'b0; t_tick = 1'b0;
                        step();
                        checks++; if (busy !== 1'b0 || done !== '0) begin errors++;
                            $display("FAIL rnd_idle it%0d got busy=%b done=%b exp 0 0", it, busy, done); end
                        fin = 1;
                    end
                end
            end
            if (!fin) begin
                checks++; errors++;
                $display("FAIL rnd_timeout it%0d got %0d of %0d ticks without done", it, cnt, need);
                do_reset();
                ptr_m = 0;
            end
            t_tick = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0; req = '0; t_tick = 1'b0;
        req_ps = '0; req_period = '0; req_reps = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_reps_zero();
        test_abort();
        test_abort_final_tick();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion exp finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_timer_sched

`default_nettype wire
